rs_muldiv_multi: RTL and testbench

- Multi-entry reservation station for the Tomasulo multiply/divide unit.
- Accepts issued instructions whose source operands are either values or producer tags.
- Snoops the CDB for missing operands and dispatches ready entries, lowest index first, into one shared iterative mul/div execution unit.
- Presents the result with its own tag to the CDB arbiter and frees the entry when the arbiter accepts it.

---
 rtl/rs_muldiv_multi.sv | 242 ++++++++++++++++++++++++
 tb/tb_rs_muldiv_multi.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/rs_muldiv_multi.sv
// Multi-entry reservation station feeding one shared iterative MUL/DIV unit.
// Optional synchronous flush port enabled by defining RS_MULDIV_FLUSH_EN.

module rs_muldiv_entry #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             load,
  input  logic [2:0]       ld_op,
  input  logic [XLEN-1:0]  ld_vj,
  input  logic [TAG_W-1:0] ld_qj,
  input  logic [XLEN-1:0]  ld_vk,
  input  logic [TAG_W-1:0] ld_qk,
  input  logic             cdb_valid,
  input  logic [TAG_W-1:0] cdb_tag,
  input  logic [XLEN-1:0]  cdb_data,
  input  logic             dispatch,
  input  logic             rel,
  output logic             free,
  output logic             rdy,
  output logic [2:0]       op,
  output logic [XLEN-1:0]  vj,
  output logic [XLEN-1:0]  vk
);
  typedef enum logic [1:0] {E_FREE, E_WAIT, E_READY, E_EXEC} ent_st_t;
  ent_st_t st;
  logic [TAG_W-1:0] qj, qk;
  logic hit_j, hit_k;

  assign hit_j = cdb_valid && (qj != '0) && (cdb_tag == qj);
  assign hit_k = cdb_valid && (qk != '0) && (cdb_tag == qk);
  assign free  = (st == E_FREE);
  assign rdy   = (st == E_READY);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st <= E_FREE;
      op <= '0;
      vj <= '0;
      vk <= '0;
      qj <= '0;
      qk <= '0;
    end else if (flush) begin
      st <= E_FREE;
    end else begin
      case (st)
        E_FREE: if (load) begin
          op <= ld_op;
          vj <= ld_vj;
          vk <= ld_vk;
          qj <= ld_qj;
          qk <= ld_qk;
          st <= ((ld_qj == '0) && (ld_qk == '0)) ? E_READY : E_WAIT;
        end
        E_WAIT: begin
          if (hit_j) begin vj <= cdb_data; qj <= '0; end
          if (hit_k) begin vk <= cdb_data; qk <= '0; end
          // Ready as soon as the last missing operand lands on this edge
          if ((hit_j || qj == '0) && (hit_k || qk == '0)) st <= E_READY;
        end
        E_READY: if (dispatch) st <= E_EXEC;
        E_EXEC:  if (rel) st <= E_FREE;
        default: st <= E_FREE;
      endcase
    end
  end
endmodule

module rs_muldiv_multi #(
  parameter int NUM_ENTRIES = 4,
  parameter int XLEN        = 32,
  parameter int TAG_W       = 5,
  parameter int TAG_BASE    = 1,
  parameter int MUL_LAT     = 4,
  parameter int DIV_LAT     = 16
) (
  input  logic                   clk,
  input  logic                   rst,
`ifdef RS_MULDIV_FLUSH_EN
  input  logic                   flush,
`endif
  input  logic                   issue_valid,
  output logic                   issue_ready,
  input  logic [2:0]             issue_op,
  input  logic [XLEN-1:0]        issue_vj,
  input  logic [TAG_W-1:0]       issue_qj,
  input  logic [XLEN-1:0]        issue_vk,
  input  logic [TAG_W-1:0]       issue_qk,
  output logic [TAG_W-1:0]       issue_tag,
  input  logic                   cdb_valid,
  input  logic [TAG_W-1:0]       cdb_tag,
  input  logic [XLEN-1:0]        cdb_data,
  output logic                   res_valid,
  output logic [TAG_W-1:0]       res_tag,
  output logic [XLEN-1:0]        res_data,
  input  logic                   res_ready,
  output logic [NUM_ENTRIES-1:0] busy
);
  localparam int IDX_W  = (NUM_ENTRIES > 1) ? $clog2(NUM_ENTRIES) : 1;
  localparam int MAXLAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
  localparam int CNT_W  = $clog2(MAXLAT + 1);

  typedef enum logic [1:0] {S_IDLE, S_EXE, S_DONE} ex_st_t;

  logic flush_i;
`ifdef RS_MULDIV_FLUSH_EN
  assign flush_i = flush;
`else
  assign flush_i = 1'b0;
`endif

  logic [NUM_ENTRIES-1:0]           ent_free, ent_rdy, ent_load, ent_disp, ent_rel;
  logic [NUM_ENTRIES-1:0][2:0]      ent_op;
  logic [NUM_ENTRIES-1:0][XLEN-1:0] ent_vj, ent_vk;

  logic             free_any, rdy_any, do_issue, ex_disp, ex_rel;
  logic [IDX_W-1:0] free_idx, rdy_idx, ex_idx;
  logic             byp_j, byp_k;
  logic [XLEN-1:0]  ld_vj, ld_vk;
  logic [TAG_W-1:0] ld_qj, ld_qk;

  ex_st_t           ex_st, ex_nxt;
  logic [2:0]       ex_op;
  logic [XLEN-1:0]  ex_a, ex_b, alu;
  logic [CNT_W-1:0] cnt;
  logic [2*XLEN-1:0] prod;

  // Lowest-index priority encoders for allocation and dispatch
  always_comb begin
    free_any = 1'b0;
    free_idx = '0;
    rdy_any  = 1'b0;
    rdy_idx  = '0;
    for (int i = NUM_ENTRIES-1; i >= 0; i--) begin
      if (ent_free[i]) begin free_any = 1'b1; free_idx = IDX_W'(i); end
      if (ent_rdy[i])  begin rdy_any  = 1'b1; rdy_idx  = IDX_W'(i); end
    end
  end

  assign issue_ready = free_any;
  assign issue_tag   = free_any ? (TAG_W'(TAG_BASE) + TAG_W'(free_idx)) : '0;
  assign do_issue    = issue_valid && free_any && !flush_i;
  assign busy        = ~ent_free;

  // A producer broadcasting in the issue cycle would otherwise be missed
  assign byp_j = cdb_valid && (issue_qj != '0) && (cdb_tag == issue_qj);
  assign byp_k = cdb_valid && (issue_qk != '0) && (cdb_tag == issue_qk);
  assign ld_vj = byp_j ? cdb_data : issue_vj;
  assign ld_qj = byp_j ? '0 : issue_qj;
  assign ld_vk = byp_k ? cdb_data : issue_vk;
  assign ld_qk = byp_k ? '0 : issue_qk;

  for (genvar g = 0; g < NUM_ENTRIES; g++) begin : g_ent
    assign ent_load[g] = do_issue && (free_idx == IDX_W'(g));
    assign ent_disp[g] = ex_disp  && (rdy_idx  == IDX_W'(g));
    assign ent_rel[g]  = ex_rel   && (ex_idx   == IDX_W'(g));
    rs_muldiv_entry #(.XLEN(XLEN), .TAG_W(TAG_W)) u_ent (
      .clk(clk), .rst(rst), .flush(flush_i),
      .load(ent_load[g]), .ld_op(issue_op),
      .ld_vj(ld_vj), .ld_qj(ld_qj), .ld_vk(ld_vk), .ld_qk(ld_qk),
      .cdb_valid(cdb_valid && !flush_i), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
      .dispatch(ent_disp[g]), .rel(ent_rel[g]),
      .free(ent_free[g]), .rdy(ent_rdy[g]),
      .op(ent_op[g]), .vj(ent_vj[g]), .vk(ent_vk[g])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ex_st <= S_IDLE;
    else     ex_st <= ex_nxt;
  end

  always_comb begin
    ex_nxt  = ex_st;
    ex_disp = 1'b0;
    ex_rel  = 1'b0;
    case (ex_st)
      S_IDLE: if (rdy_any) begin ex_disp = 1'b1; ex_nxt = S_EXE; end
      S_EXE:  if (cnt == '0) ex_nxt = S_DONE;
      S_DONE: if (res_ready) begin ex_rel = 1'b1; ex_nxt = S_IDLE; end
      default: ex_nxt = S_IDLE;
    endcase
    if (flush_i) begin
      ex_nxt  = S_IDLE;
      ex_disp = 1'b0;
      ex_rel  = 1'b0;
    end
  end

  assign prod = {{XLEN{1'b0}}, ex_a} * {{XLEN{1'b0}}, ex_b};

  always_comb begin
    alu = '0;
    case (ex_op)
      3'd0: alu = prod[XLEN-1:0];
      3'd1: alu = prod[2*XLEN-1:XLEN];
      3'd2: alu = (ex_b == '0) ? '1   : ex_a / ex_b;
      3'd3: alu = (ex_b == '0) ? ex_a : ex_a % ex_b;
      default: alu = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_op     <= '0;
      ex_a      <= '0;
      ex_b      <= '0;
      ex_idx    <= '0;
      cnt       <= '0;
      res_valid <= 1'b0;
      res_tag   <= '0;
      res_data  <= '0;
    end else if (flush_i) begin
      res_valid <= 1'b0;
    end else begin
      case (ex_st)
        S_IDLE: if (ex_disp) begin
          ex_op  <= ent_op[rdy_idx];
          ex_a   <= ent_vj[rdy_idx];
          ex_b   <= ent_vk[rdy_idx];
          ex_idx <= rdy_idx;
          cnt    <= ((ent_op[rdy_idx] == 3'd2) || (ent_op[rdy_idx] == 3'd3)) ?
                    CNT_W'(DIV_LAT - 1) : CNT_W'(MUL_LAT - 1);
        end
        S_EXE: begin
          if (cnt == '0) begin
            res_valid <= 1'b1;
            res_tag   <= TAG_W'(TAG_BASE) + TAG_W'(ex_idx);
            res_data  <= alu;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        S_DONE: if (res_ready) res_valid <= 1'b0;
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_rs_muldiv_multi.sv
// Bench for rs_muldiv_multi: vector table plus wakeup/bypass/full/reset sequences,
// results checked by a scoreboard queue as the CDB grant accepts them.
module tb_rs_muldiv_multi;
  logic        clk, rst;
  logic        issue_valid, issue_ready;
  logic [2:0]  issue_op;
  logic [31:0] issue_vj, issue_vk;
  logic [4:0]  issue_qj, issue_qk, issue_tag;
  logic        cdb_valid;
  logic [4:0]  cdb_tag;
  logic [31:0] cdb_data;
  logic        res_valid, res_ready;
  logic [4:0]  res_tag;
  logic [31:0] res_data;
  logic [3:0]  busy;
`ifdef RS_MULDIV_FLUSH_EN
  logic        flush;
`endif

  rs_muldiv_multi dut (
    .clk(clk), .rst(rst),
`ifdef RS_MULDIV_FLUSH_EN
    .flush(flush),
`endif
    .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_op(issue_op),
    .issue_vj(issue_vj), .issue_qj(issue_qj), .issue_vk(issue_vk), .issue_qk(issue_qk),
    .issue_tag(issue_tag), .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
    .res_valid(res_valid), .res_tag(res_tag), .res_data(res_data),
    .res_ready(res_ready), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] vj;
    logic [31:0] vk;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  typedef struct {
    logic [4:0]  tag;
    logic [31:0] data;
  } res_t;

  res_t exp_q[$];
  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic push(input logic [4:0] t, input logic [31:0] d);
    res_t r;
    r.tag = t;
    r.data = d;
    exp_q.push_back(r);
  endtask

  // Handshake seen at negedge is accepted on the following posedge
  always @(negedge clk) begin
    if (!rst && res_valid && res_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_result actual tag=%0d data=%0h", res_tag, res_data);
      end else begin
        res_t r;
        r = exp_q.pop_front();
        chk("res_tag", 64'(res_tag), 64'(r.tag));
        chk("res_data", 64'(res_data), 64'(r.data));
      end
    end
  end

  task automatic wait_res(input int maxc, output int n);
    n = 0;
    while (!res_valid && n < maxc) begin
      tick();
      n++;
    end
  endtask

  task automatic drain(input string name, input int maxc);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < maxc) begin
      tick();
      n++;
    end
    chk(name, 64'(exp_q.size()), 64'd0);
  endtask

  task automatic set_issue(input logic [2:0] op, input logic [31:0] vj, input logic [4:0] qj,
                           input logic [31:0] vk, input logic [4:0] qk);
    issue_valid = 1'b1;
    issue_op = op;
    issue_vj = vj;
    issue_qj = qj;
    issue_vk = vk;
    issue_qk = qk;
  endtask

  vec_t vecs[8];

  initial begin
    int n;
    logic [4:0]  hold_tag;
    logic [31:0] hold_data;

    vecs[0] = '{3'd0, 32'd7,          32'd6,          32'd42,         4};
    vecs[1] = '{3'd2, 32'd100,        32'd0,          32'hFFFFFFFF,   16};
    vecs[2] = '{3'd3, 32'd100,        32'd7,          32'd2,          16};
    vecs[3] = '{3'd1, 32'hFFFFFFFF,   32'hFFFFFFFF,   32'hFFFFFFFE,   4};
    vecs[4] = '{3'd0, 32'h00010000,   32'h00010000,   32'd0,          4};
    vecs[5] = '{3'd3, 32'd5,          32'd0,          32'd5,          16};
    vecs[6] = '{3'd2, 32'd100,        32'd7,          32'd14,         16};
    vecs[7] = '{3'd5, 32'd9,          32'd9,          32'd0,          4};

    rst = 1'b1;
    issue_valid = 0; issue_op = 0; issue_vj = 0; issue_qj = 0; issue_vk = 0; issue_qk = 0;
    cdb_valid = 0; cdb_tag = 0; cdb_data = 0; res_ready = 0;
`ifdef RS_MULDIV_FLUSH_EN
    flush = 0;
`endif
    #12 rst = 1'b0;
    tick();
    chk("reset_res_valid", 64'(res_valid), 64'd0);
    chk("reset_res_tag", 64'(res_tag), 64'd0);
    chk("reset_res_data", 64'(res_data), 64'd0);
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_issue_ready", 64'(issue_ready), 64'd1);

    // Table: independent operands, one instruction at a time
    res_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      set_issue(vecs[i].op, vecs[i].vj, 5'd0, vecs[i].vk, 5'd0);
      chk("vec_issue_tag", 64'(issue_tag), 64'd1);
      push(5'd1, vecs[i].exp);
      tick();
      issue_valid = 1'b0;
      wait_res(40, n);
      chk("vec_latency", 64'(n), 64'(vecs[i].lat + 1));
      tick();
      chk("vec_busy_free", 64'(busy), 64'd0);
      chk("vec_res_valid_low", 64'(res_valid), 64'd0);
    end

    // CDB wakeup: single operand and both operands on one broadcast
    set_issue(3'd0, 32'd0, 5'd9, 32'd3, 5'd0);
    push(5'd1, 32'd15);
    tick();
    set_issue(3'd0, 32'd0, 5'd9, 32'd0, 5'd9);
    push(5'd2, 32'd25);
    tick();
    issue_valid = 1'b0;
    chk("wake_busy", 64'(busy), 64'h3);
    cdb_valid = 1'b1; cdb_tag = 5'd9; cdb_data = 32'd5;
    tick();
    cdb_valid = 1'b0;
    wait_res(20, n);
    chk("wake_latency", 64'(n), 64'd5);
    drain("wake_drain", 40);

    // Issue-cycle bypass of a broadcast that is never repeated
    set_issue(3'd0, 32'd0, 5'd9, 32'd2, 5'd0);
    cdb_valid = 1'b1; cdb_tag = 5'd9; cdb_data = 32'd11;
    push(5'd1, 32'd22);
    tick();
    issue_valid = 1'b0;
    cdb_valid = 1'b0;
    drain("bypass_drain", 40);

    // Fill all entries, ignore a fifth issue, backpressure the result
    res_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      set_issue(3'd0, 32'd0, 5'd9, 32'(i + 1), 5'd0);
      chk("fill_issue_tag", 64'(issue_tag), 64'(i + 1));
      tick();
    end
    set_issue(3'd0, 32'd1, 5'd0, 32'd1, 5'd0);
    chk("full_issue_ready", 64'(issue_ready), 64'd0);
    tick();
    issue_valid = 1'b0;
    chk("full_busy", 64'(busy), 64'hF);
    cdb_valid = 1'b1; cdb_tag = 5'd9; cdb_data = 32'd10;
    for (int i = 0; i < 4; i++) push(5'(i + 1), 32'(10 * (i + 1)));
    tick();
    cdb_valid = 1'b0;
    wait_res(20, n);
    chk("hold_res_valid_rise", 64'(res_valid), 64'd1);
    hold_tag = res_tag;
    hold_data = res_data;
    chk("hold_first_tag", 64'(hold_tag), 64'd1);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("hold_valid", 64'(res_valid), 64'd1);
      chk("hold_tag", 64'(res_tag), 64'(hold_tag));
      chk("hold_data", 64'(res_data), 64'(hold_data));
    end
    res_ready = 1'b1;
    drain("full_drain", 100);
    chk("full_busy_after", 64'(busy), 64'd0);

    // Asynchronous reset in the middle of a divide
    set_issue(3'd2, 32'd100, 5'd0, 32'd7, 5'd0);
    tick();
    issue_valid = 1'b0;
    tick(); tick(); tick();
    chk("pre_reset_busy", 64'(busy), 64'h1);
    rst = 1'b1;
    #1;
    chk("async_busy", 64'(busy), 64'd0);
    chk("async_res_valid", 64'(res_valid), 64'd0);
    chk("async_res_tag", 64'(res_tag), 64'd0);
    tick();
    rst = 1'b0;
    tick();
    chk("post_reset_ready", 64'(issue_ready), 64'd1);
    for (int i = 0; i < 20; i++) tick();
    chk("post_reset_res_valid", 64'(res_valid), 64'd0);

`ifdef RS_MULDIV_FLUSH_EN
    // Flush while a result waits for the grant; issue in the flush cycle is dropped
    res_ready = 1'b0;
    set_issue(3'd0, 32'd3, 5'd0, 32'd3, 5'd0);
    tick();
    set_issue(3'd0, 32'd0, 5'd9, 32'd1, 5'd0);
    tick();
    issue_valid = 1'b0;
    wait_res(20, n);
    chk("flush_res_valid_before", 64'(res_valid), 64'd1);
    flush = 1'b1;
    set_issue(3'd0, 32'd1, 5'd0, 32'd1, 5'd0);
    res_ready = 1'b1;
    tick();
    flush = 1'b0;
    issue_valid = 1'b0;
    chk("flush_res_valid", 64'(res_valid), 64'd0);
    chk("flush_busy", 64'(busy), 64'd0);
    for (int i = 0; i < 10; i++) tick();
`endif

    res_ready = 1'b0;
    tick();
    chk("final_queue_empty", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
